// File: rtl/noc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | noc_pkg: shared router constants, port index enum and helpers.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package noc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int PORT_COUNT = 5;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_idx_t;

  // Address width for a power-of-two slot count, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fifo_mem: flit storage, one synchronous write port, async read port.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fifo_mem
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter int DEPTH      = noc_pkg::FIFO_DEPTH,
  parameter int ADDR_WIDTH = noc_pkg::ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // Contents are intentionally left unreset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/router_input_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | router_input_fifo: input buffer with DRTS/CTS link handshake and FWFT. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module router_input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter int DEPTH      = noc_pkg::FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        RX,
  input  logic                         DRTS,
  input  logic                         read_en_N,
  input  logic                         read_en_E,
  input  logic                         read_en_W,
  input  logic                         read_en_S,
  input  logic                         read_en_L,
  output logic                         CTS,
  output logic [DATA_WIDTH-1:0]        Data_out,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = noc_pkg::ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

  logic                  r_cts;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_cts_in;
  logic                  w_write_en;
  logic                  w_pop;
  logic                  w_read_req;
  logic [PORT_COUNT-1:0] w_read_vec;

  always_comb begin
    w_read_vec         = '0;
    w_read_vec[PORT_N] = read_en_N;
    w_read_vec[PORT_E] = read_en_E;
    w_read_vec[PORT_W] = read_en_W;
    w_read_vec[PORT_S] = read_en_S;
    w_read_vec[PORT_L] = read_en_L;
  end

  // Several arbiters granting this port at once still pop only one flit.
  assign w_read_req = |w_read_vec;
  assign empty      = (r_count == '0);
  assign full       = (r_count == c_full_count);
  assign w_pop      = w_read_req & ~empty;

  // A registered CTS must drop for a cycle between flits, halving the rate.
  assign w_cts_in   = ~r_cts & DRTS & ~full;
  assign w_write_en = w_cts_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cts    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_cts <= w_cts_in;
      if (w_write_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_write_en && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_write_en && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_write_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (RX),
    .i_raddr (r_rd_ptr),
    .o_rdata (Data_out)
  );

  assign CTS   = r_cts;
  assign count = r_count;

endmodule
`default_nettype wire
